spi_ram_responder: RTL and testbench

Bus responder for the CPU's memory bus: accepts single-byte read/write requests and services each one as a SPI transaction to an external 64 KB serial SRAM of the 23LC512 type (mode 0, byte mode). It holds `bus_wait` high for the full SPI frame and releases it when read data is valid or the write has been shifted out. The block sits between the CPU core and the chip-level SPI pins and maps the entire 16-bit address space to the SRAM.

---
 rtl/spi_ram_responder.sv | 125 ++++++++++++
 tb/tb_spi_ram_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_responder.sv
// Single-byte CPU bus responder backed by a 23LC512-style serial SRAM.
// Each bus request becomes one 32-bit SPI mode-0 frame: opcode, address, data.
module spi_ram_responder #(
  parameter int         CLK_DIV   = 1,
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_address,
  input  logic [7:0]  bus_data_from_cpu,
  output logic [7:0]  bus_data_to_cpu,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        bus_wait,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q;
  logic [31:0] shift_q;
  logic [7:0]  rx_q;
  logic [7:0]  div_q;
  logic [4:0]  bit_q;
  logic        is_read_q;
  logic        sck_q;
  logic        cs_n_q;
  logic        mosi_q;
  logic [7:0]  data_q;

  logic        request;
  logic        div_tick;
  logic [31:0] frame_d;

  assign request  = bus_read | bus_write;
  assign div_tick = (div_q == DIV_LAST);

  // A write wins when both strobes are present.
  assign frame_d = bus_write ? {CMD_WRITE, bus_address, bus_data_from_cpu}
                             : {CMD_READ, bus_address, 8'h00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 32'h0;
      rx_q      <= 8'h00;
      div_q     <= 8'h00;
      bit_q     <= 5'd0;
      is_read_q <= 1'b0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (request) begin
            is_read_q <= ~bus_write;
            shift_q   <= frame_d;
            mosi_q    <= frame_d[31];
            cs_n_q    <= 1'b0;
            sck_q     <= 1'b0;
            bit_q     <= 5'd0;
            div_q     <= 8'h00;
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          if (div_tick) begin
            div_q <= 8'h00;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rx_q <= {rx_q[6:0], spi_miso};
            end else begin
              bit_q   <= bit_q + 5'd1;
              shift_q <= {shift_q[30:0], 1'b0};
              // Last falling edge closes the frame; rx_q already holds the data byte.
              if (bit_q == 5'd31) begin
                cs_n_q  <= 1'b1;
                mosi_q  <= 1'b0;
                state_q <= DONE;
                if (is_read_q) begin
                  data_q <= rx_q;
                end
              end else begin
                mosi_q <= shift_q[30];
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end

        DONE: begin
          // Wait for the initiator to drop its request so a held one cannot retrigger.
          if (!request) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_wait        = request & (state_q != DONE);
  assign bus_data_to_cpu = data_q;
  assign spi_cs_n        = cs_n_q;
  assign spi_sck         = sck_q;
  assign spi_mosi        = mosi_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Randomized bench for spi_ram_responder: two instances (CLK_DIV 1 and 3), an SPI SRAM
// slave per instance, and a cycle-level reference model checked on every cycle.
module tb_spi_ram_responder;

  localparam logic [7:0] CR = 8'h03;
  localparam logic [7:0] CW = 8'h02;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] bus_address;
  logic [7:0]  bus_data;
  logic        rd_r   [2];
  logic        wr_r   [2];
  logic        wait_w [2];
  logic        cs_w   [2];
  logic        sck_w  [2];
  logic        mosi_w [2];
  logic        miso_w [2];
  logic [7:0]  dout_w [2];

  logic [31:0] last_frame  [2];
  int          last_pulses [2];
  int          frames      [2];
  logic [7:0]  ref_mem [2][65536];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  function automatic logic [7:0] init_byte(input int d, input logic [15:0] a);
    logic [7:0] v;
    if (a == 16'h1234) return 8'hA5;
    v = 8'(a[7:0] * 8'd37) ^ a[15:8] ^ 8'(d * 91);
    return v;
  endfunction

  function automatic int cd_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_ram_responder #(.CLK_DIV((gi == 0) ? 1 : 3)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .bus_address      (bus_address),
      .bus_data_from_cpu(bus_data),
      .bus_data_to_cpu  (dout_w[gi]),
      .bus_read         (rd_r[gi]),
      .bus_write        (wr_r[gi]),
      .bus_wait         (wait_w[gi]),
      .spi_cs_n         (cs_w[gi]),
      .spi_sck          (sck_w[gi]),
      .spi_mosi         (mosi_w[gi]),
      .spi_miso         (miso_w[gi])
    );

    logic [7:0] smem [65536];

    // SPI SRAM slave: shifts MOSI on SCK rises, drives the data byte after each fall.
    initial begin : slave
      logic [31:0] sh;
      int          cnt;
      logic        sck_p, cs_p;
      logic [15:0] sa;
      logic [7:0]  b;
      for (int i = 0; i < 65536; i++) smem[i] = init_byte(gi, 16'(i));
      sh = 0; cnt = 0; sck_p = 1'b0; cs_p = 1'b1; sa = 16'h0;
      miso_w[gi] = 1'b0; frames[gi] = 0; last_frame[gi] = 0; last_pulses[gi] = 0;
      forever begin
        @(negedge clk);
        if (cs_p === 1'b1 && cs_w[gi] === 1'b0) begin
          cnt = 0; sh = 0; frames[gi]++;
          miso_w[gi] = 1'($urandom);
        end
        if (cs_w[gi] === 1'b0 && sck_p === 1'b0 && sck_w[gi] === 1'b1) begin
          sh = {sh[30:0], mosi_w[gi]};
          cnt++;
          if (cnt == 24) sa = sh[15:0];
        end
        if (cs_w[gi] === 1'b0 && sck_p === 1'b1 && sck_w[gi] === 1'b0) begin
          if (cnt >= 24 && cnt < 32) begin
            b = smem[sa];
            miso_w[gi] = b[31 - cnt];
          end else begin
            miso_w[gi] = 1'($urandom);
          end
        end
        if (cs_p === 1'b0 && cs_w[gi] === 1'b1) begin
          last_frame[gi]  = sh;
          last_pulses[gi] = cnt;
          if (cnt == 32 && sh[31:24] == CW) smem[sh[23:8]] = sh[7:0];
        end
        sck_p = sck_w[gi];
        cs_p  = cs_w[gi];
      end
    end
  end

  // Reference model: cycle j of a frame (1..64*CLK_DIV) is in SCK half-period (j-1)/CLK_DIV,
  // and MOSI carries frame bit 31 - half/2.
  initial begin : model
    int          phase [2];
    int          j     [2];
    logic [31:0] frame [2];
    bit          isrd  [2];
    logic [7:0]  expd  [2];
    logic        req, ew, ec, es, em;
    logic [31:0] fr;
    int          h, cd;
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0; j[d] = 0; frame[d] = 0; isrd[d] = 0; expd[d] = 8'h00;
      for (int i = 0; i < 65536; i++) ref_mem[d][i] = init_byte(d, 16'(i));
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          cd  = cd_of(d);
          req = rd_r[d] | wr_r[d];
          ew = req; ec = 1'b1; es = 1'b0; em = 1'b0;
          if (phase[d] == 1) begin
            h  = (j[d] - 1) / cd;
            fr = frame[d];
            ec = 1'b0;
            es = 1'(h % 2);
            em = fr[31 - h / 2];
          end else if (phase[d] == 2) begin
            ew = 1'b0;
          end
          chk($sformatf("d%0d.bus_wait", d), {31'h0, wait_w[d]}, {31'h0, ew});
          chk($sformatf("d%0d.spi_cs_n", d), {31'h0, cs_w[d]}, {31'h0, ec});
          chk($sformatf("d%0d.spi_sck", d), {31'h0, sck_w[d]}, {31'h0, es});
          chk($sformatf("d%0d.spi_mosi", d), {31'h0, mosi_w[d]}, {31'h0, em});
          chk($sformatf("d%0d.bus_data_to_cpu", d), {24'h0, dout_w[d]}, {24'h0, expd[d]});
        end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        cd  = cd_of(d);
        req = rd_r[d] | wr_r[d];
        if (rst) begin
          phase[d] = 0; j[d] = 0; expd[d] = 8'h00;
        end else if (phase[d] == 0) begin
          if (req === 1'b1) begin
            isrd[d]  = !wr_r[d];
            frame[d] = {wr_r[d] ? CW : CR, bus_address, wr_r[d] ? bus_data : 8'h00};
            j[d]     = 1;
            phase[d] = 1;
          end
        end else if (phase[d] == 1) begin
          if (j[d] == 64 * cd) begin
            phase[d] = 2;
            fr = frame[d];
            if (isrd[d]) expd[d] = ref_mem[d][fr[23:8]];
            else ref_mem[d][fr[23:8]] = fr[7:0];
          end else begin
            j[d]++;
          end
        end else begin
          if (req !== 1'b1) phase[d] = 0;
        end
      end
    end
  end

  task automatic txn(input int d, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [7:0] dat, input int hold, input bit scr, output int wcnt);
    bit done;
    @(posedge clk); #1;
    bus_address = a; bus_data = dat; rd_r[d] = rd; wr_r[d] = wr;
    wcnt = 0; done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (wait_w[d] === 1'b1) begin
        wcnt++;
        if (scr && wcnt == 10) begin
          bus_address = 16'($urandom);
          bus_data    = 8'($urandom);
          rd_r[d]     = wr;
          wr_r[d]     = rd;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) chk($sformatf("d%0d.bus_wait_release", d), 32'd0, 32'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    rd_r[d] = 1'b0; wr_r[d] = 1'b0;
    $display("txn dut%0d rd=%0d wr=%0d addr=%h wdata=%h wait_cycles=%0d dout=%h frame=%h",
             d, rd, wr, a, dat, wcnt, dout_w[d], last_frame[d]);
  endtask

  initial begin : main
    int            w, fbefore, d, r;
    logic [15:0]   pool [8];
    logic [15:0]   a;
    rst = 1'b1; bus_address = 16'h0; bus_data = 8'h0;
    for (int i = 0; i < 2; i++) begin rd_r[i] = 1'b0; wr_r[i] = 1'b0; end
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.reset_cs_n", i), {31'h0, cs_w[i]}, 32'd1);
      chk($sformatf("d%0d.reset_sck", i), {31'h0, sck_w[i]}, 32'd0);
      chk($sformatf("d%0d.reset_mosi", i), {31'h0, mosi_w[i]}, 32'd0);
      chk($sformatf("d%0d.reset_dout", i), {24'h0, dout_w[i]}, 32'h0);
    end
    mon_en = 1'b1;

    txn(0, 1'b1, 1'b0, 16'h1234, 8'h00, 0, 1'b0, w);
    chk("read_wait_cycles", w, 32'd65);
    chk("read_frame", last_frame[0], 32'h0312_3400);
    chk("read_pulses", last_pulses[0], 32'd32);
    chk("read_data", {24'h0, dout_w[0]}, 32'hA5);

    txn(0, 1'b0, 1'b1, 16'hBEEF, 8'h3C, 0, 1'b0, w);
    chk("write_frame", last_frame[0], 32'h02BE_EF3C);
    chk("write_pulses", last_pulses[0], 32'd32);
    chk("write_keeps_dout", {24'h0, dout_w[0]}, 32'hA5);

    txn(1, 1'b1, 1'b0, 16'h0000, 8'h00, 0, 1'b0, w);
    chk("div3_wait_cycles", w, 32'd193);
    chk("div3_frame", last_frame[1], 32'h0300_0000);
    chk("div3_pulses", last_pulses[1], 32'd32);

    fbefore = frames[0];
    txn(0, 1'b1, 1'b0, 16'hBEEF, 8'h00, 5, 1'b0, w);
    repeat (4) @(negedge clk);
    chk("held_frame_count", frames[0], fbefore + 1);
    chk("readback_write", {24'h0, dout_w[0]}, 32'h3C);

    @(posedge clk); #1;
    bus_address = 16'h5A5A; rd_r[0] = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; rd_r[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_cs_n", {31'h0, cs_w[0]}, 32'd1);
    chk("midreset_sck", {31'h0, sck_w[0]}, 32'd0);
    chk("midreset_dout", {24'h0, dout_w[0]}, 32'h0);
    txn(0, 1'b1, 1'b0, 16'h1234, 8'h00, 0, 1'b0, w);
    chk("post_reset_wait", w, 32'd65);
    chk("post_reset_data", {24'h0, dout_w[0]}, 32'hA5);

    txn(0, 1'b1, 1'b1, 16'h0042, 8'h77, 0, 1'b0, w);
    chk("both_frame", last_frame[0], 32'h0200_4277);
    txn(0, 1'b1, 1'b0, 16'h0042, 8'h00, 0, 1'b0, w);
    chk("both_readback", {24'h0, dout_w[0]}, 32'h77);

    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 16'($urandom);
      txn(d, r != 2, r >= 2, a, 8'($urandom), int'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, w);
      chk($sformatf("rand%0d_pulses", n), last_pulses[d], 32'd32);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
